// File: rtl/interconnect_link_distributor.sv
// Buffered link distributor: places each packet from one local link onto one or
// more interconnect planes (broadcast, round-robin or tag-select), one FIFO per plane.
module interconnect_link_distributor #(
    parameter int NUM_PLANES   = 4,
    parameter int BUFFER_DEPTH = 2,
    parameter int TAG_WIDTH    = 4,
    parameter int DATA_WIDTH   = 8,
    localparam int CW          = $clog2(BUFFER_DEPTH + 1),
    localparam int SW          = $clog2(NUM_PLANES)
) (
    input  logic                                   clk,
    input  logic                                   n_reset,
    input  logic [1:0]                             mode,
    input  logic                                   input_link_req,
    output logic                                   input_link_ack,
    input  logic [TAG_WIDTH-1:0]                   input_link_tag,
    input  logic [DATA_WIDTH-1:0]                  input_link_data,
    output logic [NUM_PLANES-1:0]                  output_interconnect_link_reqs,
    input  logic [NUM_PLANES-1:0]                  output_interconnect_link_acks,
    output logic [NUM_PLANES-1:0][TAG_WIDTH-1:0]   output_interconnect_link_tag_lines,
    output logic [NUM_PLANES-1:0][DATA_WIDTH-1:0]  output_interconnect_link_data_lines,
    output logic [NUM_PLANES-1:0][CW-1:0]          plane_occupancy,
    output logic                                   idle
);

    localparam int PW = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
    localparam int EW = TAG_WIDTH + DATA_WIDTH;

    // Every link is valid/ready: a packet moves in a cycle where req && ack.
    // ack never depends on req; req must not depend on ack.

    logic [NUM_PLANES-1:0] space;
    logic [NUM_PLANES-1:0] push;
    logic [NUM_PLANES-1:0] sel;
    logic [SW-1:0]         rr_ptr;
    logic [SW-1:0]         rr_target;
    logic [SW-1:0]         rr_idx;
    logic                  rr_found;
    logic [SW-1:0]         tag_target;
    logic                  ack_mode;
    logic                  xfer;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        return (ptr == PW'(BUFFER_DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    // First plane with space, searching upward from rr_ptr with wrap-around.
    always_comb begin
        rr_target = rr_ptr;
        rr_found  = 1'b0;
        rr_idx    = '0;
        for (int i = 0; i < NUM_PLANES; i++) begin
            rr_idx = rr_ptr + SW'(i);
            if (!rr_found && space[rr_idx]) begin
                rr_target = rr_idx;
                rr_found  = 1'b1;
            end
        end
    end

    assign tag_target = input_link_tag[SW-1:0];

    always_comb begin
        ack_mode = 1'b0;
        sel      = '0;
        case (mode)
            2'd1: begin
                ack_mode = |space;
                sel      = NUM_PLANES'(1) << rr_target;
            end
            2'd2: begin
                ack_mode = space[tag_target];
                sel      = NUM_PLANES'(1) << tag_target;
            end
            default: begin
                ack_mode = &space;
                sel      = '1;
            end
        endcase
    end

    assign input_link_ack = n_reset & ack_mode;
    assign xfer           = input_link_req & input_link_ack;
    assign push           = sel & {NUM_PLANES{xfer}};

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            rr_ptr <= '0;
        end else if (xfer && (mode == 2'd1)) begin
            rr_ptr <= rr_target + 1'b1;
        end
    end

    for (genvar p = 0; p < NUM_PLANES; p++) begin : g_plane
        logic [CW-1:0] count;
        logic [PW-1:0] rd_ptr;
        logic [PW-1:0] wr_ptr;
        logic [EW-1:0] mem [BUFFER_DEPTH];
        logic          pop;

        // Space comes from the registered count only, so a full FIFO never
        // accepts in the same cycle it pops.
        assign space[p]                         = count < CW'(BUFFER_DEPTH);
        assign output_interconnect_link_reqs[p] = (count != '0);
        assign pop                              = output_interconnect_link_reqs[p]
                                                  & output_interconnect_link_acks[p];
        assign plane_occupancy[p]               = count;
        assign {output_interconnect_link_tag_lines[p], output_interconnect_link_data_lines[p]} =
            output_interconnect_link_reqs[p] ? mem[rd_ptr] : '0;

        always_ff @(posedge clk or negedge n_reset) begin
            if (!n_reset) begin
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push[p]) wr_ptr <= next_ptr(wr_ptr);
                if (pop)     rd_ptr <= next_ptr(rd_ptr);
                case ({push[p], pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (push[p]) mem[wr_ptr] <= {input_link_tag, input_link_data};
        end
    end

    assign idle = ~|output_interconnect_link_reqs;

endmodule

// File: tb/tb_interconnect_link_distributor.sv
// Self-checking bench for interconnect_link_distributor: per-plane expected queues
// fed on each accepted packet and drained as each plane hands packets onward.
module tb_interconnect_link_distributor;

    localparam int NP = 4;
    localparam int D  = 2;
    localparam int TW = 4;
    localparam int DW = 8;
    localparam int CW = 2;
    localparam int EW = TW + DW;

    logic                   clk = 1'b0;
    logic                   n_reset = 1'b0;
    logic [1:0]             mode = 2'd0;
    logic                   req = 1'b0;
    logic                   ack;
    logic [TW-1:0]          tag = '0;
    logic [DW-1:0]          data = '0;
    logic [NP-1:0]          reqs;
    logic [NP-1:0]          acks = '1;
    logic [NP-1:0][TW-1:0]  tag_lines;
    logic [NP-1:0][DW-1:0]  data_lines;
    logic [NP-1:0][CW-1:0]  occ;
    logic                   idle;

    logic [EW-1:0] exp_q [NP][$];
    int  n_cmp = 0;
    int  n_err = 0;
    int  rr_m = 0;
    bit  rand_acks = 1'b0;

    int rr_seq[5]   = '{0, 1, 2, 3, 0};
    int skip_seq[4] = '{0, 2, 3, 0};
    int tag_in[4]   = '{5, 2, 7, 4};
    int tag_pl[4]   = '{1, 2, 3, 0};

    interconnect_link_distributor #(
        .NUM_PLANES(NP), .BUFFER_DEPTH(D), .TAG_WIDTH(TW), .DATA_WIDTH(DW)
    ) dut (
        .clk                                (clk),
        .n_reset                            (n_reset),
        .mode                               (mode),
        .input_link_req                     (req),
        .input_link_ack                     (ack),
        .input_link_tag                     (tag),
        .input_link_data                    (data),
        .output_interconnect_link_reqs      (reqs),
        .output_interconnect_link_acks      (acks),
        .output_interconnect_link_tag_lines (tag_lines),
        .output_interconnect_link_data_lines(data_lines),
        .plane_occupancy                    (occ),
        .idle                               (idle)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Scoreboard: predicts ack from queue depths, checks heads on every pop and
    // queues every accepted packet onto the planes it should reach.
    always @(negedge clk) begin : scoreboard
        logic [NP-1:0] space_m;
        logic [NP-1:0] tgt_m;
        logic          ack_m;
        logic          empty_m;
        int            t;
        int            rr_tgt;
        if (!n_reset) begin
            for (int p = 0; p < NP; p++) exp_q[p].delete();
            rr_m = 0;
            check("rst_reqs", reqs, 0);
            check("rst_occ", occ, 0);
            check("rst_idle", idle, 1);
            check("rst_ack", ack, 0);
        end else begin
            empty_m = 1'b1;
            for (int p = 0; p < NP; p++) begin
                space_m[p] = exp_q[p].size() < D;
                if (exp_q[p].size() != 0) empty_m = 1'b0;
            end
            tgt_m  = '0;
            ack_m  = 1'b0;
            rr_tgt = 0;
            case (mode)
                2'd1: begin
                    for (int i = 0; i < NP; i++) begin
                        t = (rr_m + i) % NP;
                        if (space_m[t] && tgt_m == '0) begin
                            tgt_m[t] = 1'b1;
                            rr_tgt   = t;
                        end
                    end
                    ack_m = |space_m;
                end
                2'd2: begin
                    t        = int'(tag) % NP;
                    tgt_m[t] = 1'b1;
                    ack_m    = space_m[t];
                end
                default: begin
                    tgt_m = '1;
                    ack_m = &space_m;
                end
            endcase
            check("ack", ack, ack_m);
            check("idle", idle, empty_m);
            for (int p = 0; p < NP; p++) begin
                check("occ", occ[p], exp_q[p].size());
                check("req", reqs[p], exp_q[p].size() != 0);
                if (acks[p] && exp_q[p].size() != 0) begin
                    check("head", {tag_lines[p], data_lines[p]}, exp_q[p][0]);
                    void'(exp_q[p].pop_front());
                end
            end
            if (req && ack_m) begin
                for (int p = 0; p < NP; p++)
                    if (tgt_m[p]) exp_q[p].push_back({tag, data});
                if (mode == 2'd1) rr_m = (rr_tgt + 1) % NP;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_acks) acks = NP'($urandom_range(0, (1 << NP) - 1));
    endtask

    task automatic send(input logic [TW-1:0] t, input logic [DW-1:0] d);
        bit done = 1'b0;
        int n = 0;
        req  = 1'b1;
        tag  = t;
        data = d;
        while (!done && n < 200) begin
            @(negedge clk);
            done = ack;
            step();
            n++;
        end
        req = 1'b0;
        check("send_done", done, 1);
    endtask

    task automatic drain();
        int n = 0;
        rand_acks = 1'b0;
        acks = '1;
        @(negedge clk);
        while (!idle && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("drain_idle", idle, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int leftover;
        repeat (2) @(posedge clk);
        #1;
        n_reset = 1'b1;

        // Broadcast: one packet reaches all planes one cycle later.
        mode = 2'd0;
        acks = '1;
        send(4'd3, 8'hA5);
        @(negedge clk);
        check("bc_reqs", reqs, 4'hF);
        for (int p = 0; p < NP; p++) check("bc_data", data_lines[p], 8'hA5);
        @(posedge clk); #1;

        // Broadcast stalls on the slowest plane.
        acks = 4'b1011;
        send(4'd0, 8'h11);
        send(4'd0, 8'h22);
        req = 1'b1; data = 8'h33;
        @(negedge clk); check("bc_full_ack", ack, 0);
        @(posedge clk); #1;
        @(negedge clk); check("bc_full_ack", ack, 0);
        @(posedge clk); #1;
        acks = '1;
        @(negedge clk); check("bc_pop_ack", ack, 0);
        @(posedge clk); #1;
        @(negedge clk); check("bc_resume_ack", ack, 1);
        @(posedge clk); #1;
        req = 1'b0;
        drain();

        // Round-robin over free planes.
        mode = 2'd1;
        for (int i = 0; i < 5; i++) begin
            send(TW'(i), DW'(8'h40 + i));
            @(negedge clk); check("rr_plane", reqs, 1 << rr_seq[i]);
            @(posedge clk); #1;
        end
        drain();

        // Reset with all FIFOs holding packets.
        mode = 2'd0;
        acks = '0;
        send(4'd1, 8'h61);
        send(4'd2, 8'h62);
        n_reset = 1'b0;
        req = 1'b1; data = 8'h63;
        @(negedge clk);
        check("mid_rst_reqs", reqs, 0);
        check("mid_rst_occ", occ, 0);
        check("mid_rst_idle", idle, 1);
        check("mid_rst_ack", ack, 0);
        @(posedge clk); #1;
        n_reset = 1'b1;
        @(negedge clk); check("rst_rel_ack", ack, 1);
        @(posedge clk); #1;
        req = 1'b0;
        drain();

        // Round-robin skips a full plane (rr pointer is back at 0 after reset).
        mode = 2'd2;
        acks = 4'b1101;
        send(4'd1, 8'h71);
        send(4'd1, 8'h72);
        mode = 2'd1;
        for (int i = 0; i < 4; i++) begin
            send(TW'(8 + i), DW'(8'h80 + i));
            @(negedge clk); check("rr_skip", reqs & 4'b1101, 1 << skip_seq[i]);
            @(posedge clk); #1;
        end
        drain();

        // Tag-select routing and per-plane blocking.
        mode = 2'd2;
        for (int i = 0; i < 4; i++) begin
            send(TW'(tag_in[i]), DW'(8'h90 + i));
            @(negedge clk); check("tag_plane", reqs, 1 << tag_pl[i]);
            @(posedge clk); #1;
        end
        acks = 4'b1011;
        send(4'd2, 8'hA1);
        send(4'd2, 8'hA2);
        req = 1'b1; tag = 4'd6; data = 8'hA3;
        @(negedge clk); check("tag_block", ack, 0);
        @(posedge clk); #1;
        tag = 4'd1;
        @(negedge clk); check("tag_pass", ack, 1);
        @(posedge clk); #1;
        req = 1'b0;
        drain();

        // Push and pop together at count 1, then a full FIFO that pops.
        mode = 2'd2;
        acks = 4'b1110;
        send(4'd0, 8'h51);
        acks = 4'b1111;
        send(4'd4, 8'h52);
        acks = 4'b1110;
        @(negedge clk);
        check("pp_count", occ[0], 1);
        check("pp_head", data_lines[0], 8'h52);
        @(posedge clk); #1;
        send(4'd0, 8'h53);
        req = 1'b1; tag = 4'd0; data = 8'h54;
        acks = 4'b1111;
        @(negedge clk); check("fp_ack0", ack, 0);
        @(posedge clk); #1;
        @(negedge clk); check("fp_ack1", ack, 1);
        @(posedge clk); #1;
        req = 1'b0;
        drain();

        // Random modes, tags and back-pressure.
        rand_acks = 1'b1;
        for (int i = 0; i < 300; i++) begin
            mode = 2'($urandom_range(0, 3));
            send(TW'($urandom_range(0, 15)), DW'($urandom_range(0, 255)));
            if ($urandom_range(0, 3) == 0) step();
        end
        drain();

        leftover = 0;
        for (int p = 0; p < NP; p++) leftover += exp_q[p].size();
        check("leftover", leftover, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/interconnect_link_distributor.md
# interconnect_link_distributor

Buffered, mode-selectable successor to the plain link splitter. It takes a single local link from a peripheral and places each packet onto one or more physical planes of an interconnect link bundle. Each plane has its own FIFO, so one stalled plane does not block the others. It sits between mesh-edge peripherals (memories, host bridges) and the router ports of the mesh.

## Interface
- NUM_PLANES, default TIA_NUM_PHYSICAL_PLANES: number of physical planes. Must be a power of two, ≥ 2.
- BUFFER_DEPTH, default 2: entries per plane FIFO. Must be ≥ 1.
- clk  input  1  single clock; all state updates on its rising edge.
- n_reset  input  1  asynchronous, active-low reset.
- mode  input  2  distribution mode: 0 = broadcast, 1 = round-robin, 2 = tag-select, 3 = reserved (treated as broadcast).
- input_link  link_if.receiver  req/ack + packet{tag, data}  local source link.
- output_interconnect_link  interconnect_link_if.sender  reqs/acks/tag_lines/data_lines, NUM_PLANES wide  plane bundle toward the mesh.
- plane_occupancy  output  NUM_PLANES × $clog2(BUFFER_DEPTH+1)  per-plane FIFO fill count.
- idle  output  1  high when all FIFOs are empty.

## Operation
- Handshake, valid/ready style on all links: a transfer occurs in a cycle where req && ack.
- Per-plane FIFO p:
  - Holds {tag, data}.
  - reqs[p] = (count[p] != 0); tag_lines[p] and data_lines[p] show the head entry.
  - Pop when reqs[p] && acks[p].
- Space check: space[p] = (count[p] < BUFFER_DEPTH), taken from registered count only. There is no pop-through, so a full FIFO does not accept a packet in the same cycle it pops.
- input_link.ack is combinational from mode, packet.tag, space[] and rr_ptr. It is independent of input_link.req.
- Broadcast (mode 0/3):
  - ack = &space.
  - On transfer, push the packet to every FIFO.
  - Exactly one input transfer per packet; no partial pushes.
- Round-robin (mode 1):
  - The target is the first plane p with space[p], searching from rr_ptr upward with wrap-around.
  - ack = |space.
  - On transfer, push to the target only and set rr_ptr = target+1 mod NUM_PLANES.
  - rr_ptr is unchanged when there is no transfer.
- Tag-select (mode 2):
  - target = packet.tag[$clog2(NUM_PLANES)-1:0].
  - ack = space[target].
  - On transfer, push to the target only.
- mode is quasi-static. It is sampled combinationally each cycle, so a change affects the next transfer. Packets already buffered are unaffected.
- Simultaneous push and pop on the same FIFO: count is unchanged, the head advances, and the new entry is appended.
- Ordering:
  - FIFO order is preserved per plane.
  - No ordering is guaranteed across planes.
- plane_occupancy[p] = count[p]. idle = all counts zero.

## Timing
- Reset (n_reset low, asynchronous): all FIFOs empty, rr_ptr = 0.
  - reqs = 0, plane_occupancy = 0, idle = 1.
  - input_link.ack = 0 while n_reset is low.
  - Tag/data lines are don't-care (driven to 0).
- Reset asserted mid-operation discards all buffered packets immediately. No partial state survives.
- Latency: a packet accepted in cycle N is visible on reqs[p] in cycle N+1.
- Throughput: one packet per cycle into any plane whose FIFO is not full. With BUFFER_DEPTH ≥ 2 and acks held high, a single plane sustains one packet per cycle.
- Broadcast throughput is bounded by the slowest plane.
- Round-robin skips full planes without adding bubbles.

## Test plan
- Reset/idle: assert n_reset low mid-traffic with FIFOs partly full → next cycle reqs = 0, occupancy = 0, idle = 1, ack = 0. Release reset → ack = 1 in broadcast mode.
- Broadcast (NUM_PLANES=4, BUFFER_DEPTH=2), all acks = 1:
  - Send tag=3, data=0xA5 at cycle 0 → reqs = 4'b1111 with data 0xA5 on every plane at cycle 1.
  - Hold acks[2] = 0 and send 2 more packets → plane 2 fills. ack drops to 0 until acks[2] pops one entry.
- Round-robin, all acks = 1: send 5 packets → they land on planes 0,1,2,3,0 in order.
  - Repeat with plane 1 full → the sequence skips plane 1: 0,2,3,0.
- Tag-select: packets with tags 5,2,7,4 → planes 1,2,3,0.
  - With plane 2 full, a tag=6 packet waits (ack = 0) while tag=1 can still be accepted.
- Simultaneous push and pop on one FIFO at count = 1 → count stays 1 and FIFO order is intact.
  - Full FIFO with pop active → ack = 0 that cycle and 1 the next.
